// File: rtl/knap_search_ctrl.sv
// Exhaustive knapsack search controller: steps a selection mask through every
// subset of a programmable item table and tracks the best subset that meets the limits.
module knap_search_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int W       = 32,
  localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_wr,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [W-1:0]       cfg_value,
  input  logic [W-1:0]       cfg_weight,
  input  logic [W-1:0]       min_value,
  input  logic [W-1:0]       max_weight,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [W-1:0]       best_value,
  output logic [W-1:0]       best_weight,
  output logic [N_ITEMS:0]   valid_count,
  output logic [1:0]         dbg_state
);

  // Handshake: start is accepted on any rising edge where the block is in IDLE;
  // busy stays high from the accepting edge until the edge after the done pulse
  // begins, and done is a single-cycle pulse that only a completed search raises.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [W-1:0]       tbl_value  [N_ITEMS];
  logic [W-1:0]       tbl_weight [N_ITEMS];
  logic [N_ITEMS-1:0] mask;
  logic [W-1:0]       min_lat, max_lat;
  logic [W-1:0]       sum_value, sum_weight;
  logic               subset_ok, last_mask, idx_ok;

  assign dbg_state = state;
  assign idx_ok    = 32'(cfg_idx) < N_ITEMS;
  assign last_mask = &mask;

  // Single combinational adder tree over the items selected by the current mask.
  always_comb begin
    sum_value  = '0;
    sum_weight = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (mask[i]) begin
        sum_value  = sum_value + tbl_value[i];
        sum_weight = sum_weight + tbl_weight[i];
      end
    end
    subset_ok = (sum_value >= min_lat) && (sum_weight <= max_lat);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = EVAL;
      EVAL: begin
        if (abort)          next_state = IDLE;
        else if (last_mask) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        tbl_value[i]  <= '0;
        tbl_weight[i] <= '0;
      end
    end else if (state == IDLE && cfg_wr && idx_ok) begin
      tbl_value[cfg_idx]  <= cfg_value;
      tbl_weight[cfg_idx] <= cfg_weight;
    end
  end

  // busy also covers the DONE cycle so it falls one edge after done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      best_mask   <= '0;
      best_value  <= '0;
      best_weight <= '0;
      valid_count <= '0;
      mask        <= '0;
      min_lat     <= '0;
      max_lat     <= '0;
    end else begin
      done <= (state == DONE);
      busy <= (next_state != IDLE) || (state == DONE);
      if (state == IDLE && start) begin
        min_lat     <= min_value;
        max_lat     <= max_weight;
        found       <= 1'b0;
        best_mask   <= '0;
        best_value  <= '0;
        best_weight <= '0;
        valid_count <= '0;
        mask        <= '0;
      end else if (state == EVAL) begin
        mask <= mask + N_ITEMS'(1);
        if (subset_ok) begin
          valid_count <= valid_count + (N_ITEMS+1)'(1);
          // Strictly greater keeps the lower mask on ties.
          if (!found || sum_value > best_value) begin
            found       <= 1'b1;
            best_mask   <= mask;
            best_value  <= sum_value;
            best_weight <= sum_weight;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Self-checking bench for knap_search_ctrl: directed scenarios plus randomized
// tables compared against an enumerate-all-subsets reference model.
module tb_knap_search_ctrl;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int RW = 1 + N + W + W + N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_wr = 1'b0;
  logic [2:0]   cfg_idx = '0;
  logic [W-1:0] cfg_value = '0, cfg_weight = '0;
  logic [W-1:0] min_value = '0, max_weight = '0;
  logic         start = 1'b0, abort = 1'b0;
  logic         busy, done, found;
  logic [N-1:0] best_mask;
  logic [W-1:0] best_value, best_weight;
  logic [N:0]   valid_count;
  logic [1:0]   dbg_state;
  logic [RW-1:0] got, exp_r;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] tv [N];
  logic [W-1:0] tw [N];
  int done_at[$];
  int busy_low;

  knap_search_ctrl #(.N_ITEMS(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
    .cfg_value(cfg_value), .cfg_weight(cfg_weight), .min_value(min_value),
    .max_weight(max_weight), .start(start), .abort(abort), .busy(busy),
    .done(done), .found(found), .best_mask(best_mask), .best_value(best_value),
    .best_weight(best_weight), .valid_count(valid_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign got = {found, best_mask, best_value, best_weight, valid_count};

  // Reference: enumerate subsets 0..last, keep the first subset with the highest value.
  function automatic logic [RW-1:0] model(input logic [W-1:0] mn, input logic [W-1:0] mx,
                                          input int last);
    logic         f;
    logic [N-1:0] bm;
    logic [W-1:0] bv, bw, sv, sw;
    int           cnt;
    f = 1'b0; bm = '0; bv = '0; bw = '0; cnt = 0;
    for (int k = 0; k <= last; k++) begin
      sv = '0; sw = '0;
      for (int i = 0; i < N; i++) begin
        if (k[i]) begin
          sv = sv + tv[i];
          sw = sw + tw[i];
        end
      end
      if (sv >= mn && sw <= mx) begin
        cnt++;
        if (!f || sv > bv) begin
          f = 1'b1; bm = k[N-1:0]; bv = sv; bw = sw;
        end
      end
    end
    return {f, bm, bv, bw, (N+1)'(cnt)};
  endfunction

  task automatic write_item(input int idx, input logic [W-1:0] v, input logic [W-1:0] w);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_idx = idx[2:0]; cfg_value = v; cfg_weight = w;
    @(posedge clk);
    #1 cfg_wr = 1'b0;
    if (idx < N) begin
      tv[idx] = v;
      tw[idx] = w;
    end
  endtask

  task automatic write_case1();
    logic [W-1:0] v [N];
    logic [W-1:0] w [N];
    v = '{4, 2, 2, 1, 10};
    w = '{12, 1, 2, 1, 4};
    for (int i = 0; i < N; i++) write_item(i, v[i], w[i]);
  endtask

  task automatic start_search(input logic [W-1:0] mn, input logic [W-1:0] mx);
    @(negedge clk);
    start = 1'b1; min_value = mn; max_weight = mx;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c is observed #1 after edge c (edge 0 accepted the start); stimulus
  // injected at cycle c is sampled at edge c+1.
  task automatic run_window(input int ncyc, input int inj_at, input bit inj_wr,
                            input logic [W-1:0] inj_min, input logic [W-1:0] inj_max,
                            input int abort_at);
    done_at.delete();
    busy_low = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0; cfg_wr = 1'b0; abort = 1'b0;
      if (done) done_at.push_back(c);
      if (!busy && busy_low < 0) busy_low = c;
      if (c == inj_at) begin
        start = 1'b1; min_value = inj_min; max_weight = inj_max;
        cfg_wr = inj_wr; cfg_idx = 3'd0; cfg_value = 32'd99; cfg_weight = 32'd0;
      end
      if (c == abort_at) abort = 1'b1;
    end
  endtask

  task automatic check_single_done(input string name);
    checks++;
    if (done_at.size() != 1 || done_at[0] != 33) begin
      errors++;
      $display("FAIL %s_done_timing pulses=%0d first=%0d required one pulse at cycle 33",
               name, done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({got, busy, done, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h busy=%b done=%b state=%0d required all zero",
               got, busy, done, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    write_case1();
    start_search(15, 16);
    run_window(40, 0, 1'b0, 0, 0, 0);
    check_single_done("basic");
    checks++;
    if (busy_low != 34) begin
      errors++;
      $display("FAIL basic_busy_fall got=%0d required 34", busy_low);
    end
    exp_r = {1'b1, 5'h1E, 32'd15, 32'd8, 6'd1};
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL basic_result got=%h required=%h", got, exp_r);
    end
    checks++;
    if (got !== model(15, 16, 31)) begin
      errors++;
      $display("FAIL basic_model got=%h required=%h", got, model(15, 16, 31));
    end
  endtask

  task automatic test_no_valid();
    start_search(20, 16);
    run_window(40, 0, 1'b0, 0, 0, 0);
    check_single_done("no_valid");
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL no_valid_result got=%h required=0", got);
    end
  endtask

  task automatic test_tie();
    for (int i = 0; i < N; i++) write_item(i, 1, 1);
    start_search(0, 1);
    run_window(40, 0, 1'b0, 0, 0, 0);
    check_single_done("tie");
    exp_r = {1'b1, 5'h01, 32'd1, 32'd1, 6'd6};
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL tie_result got=%h required=%h", got, exp_r);
    end
  endtask

  task automatic test_abort();
    write_case1();
    start_search(15, 16);
    run_window(12, 0, 1'b0, 0, 0, 5);
    checks++;
    if (done_at.size() != 0 || busy_low != 6) begin
      errors++;
      $display("FAIL abort_timing pulses=%0d busy_low=%0d required 0 pulses, busy low at 6",
               done_at.size(), busy_low);
    end
    checks++;
    if (got !== model(15, 16, 5) || valid_count !== 6'd0) begin
      errors++;
      $display("FAIL abort_partial got=%h required=%h", got, model(15, 16, 5));
    end
    write_item(1, 3, 1);
    start_search(15, 16);
    run_window(40, 0, 1'b0, 0, 0, 0);
    check_single_done("after_abort");
    checks++;
    if (got !== model(15, 16, 31)) begin
      errors++;
      $display("FAIL after_abort_result got=%h required=%h", got, model(15, 16, 31));
    end
  endtask

  task automatic test_busy_ignore();
    write_case1();
    start_search(15, 16);
    run_window(40, 10, 1'b1, 0, 100, 0);
    check_single_done("busy_ignore");
    exp_r = {1'b1, 5'h1E, 32'd15, 32'd8, 6'd1};
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL busy_ignore_result got=%h required=%h", got, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    start_search(15, 16);
    run_window(80, 33, 1'b0, 0, 16, 0);
    checks++;
    if (done_at.size() != 2 || done_at[0] != 33 || done_at[1] != 67 || busy_low != 68) begin
      errors++;
      $display("FAIL b2b_timing pulses=%0d busy_low=%0d required pulses at 33,67 busy low at 68",
               done_at.size(), busy_low);
    end
    checks++;
    if (got !== model(0, 16, 31)) begin
      errors++;
      $display("FAIL b2b_result got=%h required=%h", got, model(0, 16, 31));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] mn, mx;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        if (it == 5) write_item(i, $urandom, $urandom);
        else write_item(i, $urandom_range(0, 15), $urandom_range(0, 15));
      end
      write_item($urandom_range(5, 7), $urandom, 0);
      mn = (it == 5) ? $urandom : $urandom_range(0, 40);
      mx = (it == 5) ? $urandom : $urandom_range(0, 40);
      start_search(mn, mx);
      run_window(40, 0, 1'b0, 0, 0, 0);
      check_single_done("random");
      checks++;
      if (got !== model(mn, mx, 31)) begin
        errors++;
        $display("FAIL random_result it=%0d got=%h required=%h", it, got, model(mn, mx, 31));
      end
    end
  endtask

  task automatic test_reset_mid();
    start_search(0, 0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({got, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got=%h busy=%b done=%b required all zero", got, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      tv[i] = '0;
      tw[i] = '0;
    end
    start_search(0, 0);
    run_window(40, 0, 1'b0, 0, 0, 0);
    check_single_done("reset_mid");
    exp_r = {1'b1, 5'h00, 32'd0, 32'd0, 6'd32};
    checks++;
    if (got !== exp_r) begin
      errors++;
      $display("FAIL reset_mid_result got=%h required=%h", got, exp_r);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      tv[i] = '0;
      tw[i] = '0;
    end
    test_reset();
    test_basic();
    test_no_valid();
    test_tie();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
